conv2d_stream: RTL and testbench
================================

CONV2D_STREAM -- requirements
Module: conv2d_stream

Interface
REQ-001 SHALL provide parameter DATA_W, default 4, unsigned pixel width.
REQ-002 SHALL provide parameter COEF_W, default 2, unsigned coefficient width.
REQ-003 SHALL provide parameter IMG_W, default 6, pixels per row (min 3).
REQ-004 SHALL provide parameter IMG_H, default 6, rows per frame (min 3).
REQ-005 SHALL provide parameters K0..K8, defaults 1,2,3,1,2,3,1,2,3, reset values of coefficient registers; localparam OUT_W = DATA_W+COEF_W+4.
REQ-006 SHALL have one clock; reset is asynchronous and active-high.
REQ-007 CLK  input  1  clock, all state on rising edge.
REQ-008 RST  input  1  async active-high reset.
REQ-009 IN_VALID  input  1  IN_PIXEL valid.
REQ-010 IN_READY  output  1  block accepts pixel this cycle.
REQ-011 IN_PIXEL  input  DATA_W  raster-order pixel.
REQ-012 OUT_VALID  output  1  OUT_DATA valid.
REQ-013 OUT_READY  input  1  downstream accepts OUT_DATA.
REQ-014 OUT_DATA  output  OUT_W  convolution result.
REQ-015 OUT_LAST  output  1  marks final result of frame.
REQ-016 COEF_WE  input  1  coefficient write strobe.
REQ-017 COEF_ADDR  input  4  coefficient index 0..8.
REQ-018 COEF_DATA  input  COEF_W  coefficient value.

Function
REQ-019 Transfer on a port SHALL occur only on a cycle with VALID and READY both high.
REQ-020 Block SHALL hold column counter (0..IMG_W-1) and row counter (0..IMG_H-1), advanced per accepted pixel; column wraps to 0 and increments row; after (IMG_W-1, IMG_H-1) both wrap to 0 (next frame).
REQ-021 Block SHALL keep two line buffers of IMG_W entries plus a 3x3 window register, so window W[i][j] (i row 0..2 top-down, j col 0..2 left-right) covers rows r-2..r, cols c-2..c of the pixel just accepted at (r,c).
REQ-022 State machine SHALL be FILL (row<2) -> RUN (row>=2) on acceptance of pixel (1, IMG_W-1); RUN -> FILL on acceptance of pixel (IMG_H-1, IMG_W-1).
REQ-023 Window SHALL be valid only in RUN with c>=2; no padding; exactly (IMG_W-2)*(IMG_H-2) results per frame.
REQ-024 Result SHALL be true convolution: sum over n=0..8 of W[n/3][n%3] * Kreg[8-n], unsigned, full precision in OUT_W bits, no truncation or saturation.
REQ-025 Pipeline SHALL be 2 stages (products registered, then sum registered); OUT_VALID rises 2 cycles after acceptance of the completing pixel when not stalled.
REQ-026 Stall: while OUT_VALID=1 and OUT_READY=0, pipeline, window and counters SHALL freeze, OUT_DATA/OUT_LAST held stable, IN_READY=0.
REQ-027 IN_READY SHALL equal NOT(OUT_VALID AND NOT OUT_READY) outside reset; back-to-back throughput one pixel per cycle.
REQ-028 OUT_LAST SHALL be 1 with the result of window ending at (IMG_H-1, IMG_W-1), else 0.
REQ-029 COEF_WE with COEF_ADDR<=8 SHALL write Kreg[COEF_ADDR] at clock edge, stall or not; COEF_ADDR>8 ignored.
REQ-030 New coefficient SHALL apply to windows entering stage 1 on any later edge; results already in stage 1/2 unaffected.
REQ-031 Gaps in IN_VALID SHALL not change results; bubbles propagate as OUT_VALID=0.

Reset
REQ-032 RST=1 SHALL immediately force OUT_VALID=0, OUT_LAST=0, OUT_DATA=0, IN_READY=0, counters=0, state=FILL, Kreg[n]=Kn.
REQ-033 Line buffer contents SHALL need no reset; stale data never produces a valid output.
REQ-034 Reset mid-frame SHALL discard partial frame; first pixel after release is (0,0).

Verification
REQ-035 6x6 frame, pixels (index+1) mod 16, default K, OUT_READY=1 -> 16 results, first 138, OUT_LAST only on 16th.
REQ-036 Same frame, COEF_ADDR=4 COEF_DATA=0 written before start -> first result 122.
REQ-037 All pixels 15, all Kreg 3 -> every result 405, no overflow.
REQ-038 OUT_READY low 5 cycles while OUT_VALID=1 -> OUT_DATA stable, IN_READY=0, all 16 results delivered in order, none lost or duplicated.
REQ-039 RST pulse after 20 pixels, then full frame -> no output before fresh frame's row 2 col 2, first result 138.
REQ-040 Two frames back-to-back, random IN_VALID gaps -> 32 results, second frame identical to first.

Source files
------------

// File: rtl/conv2d_stream.sv
// conv2d_stream: streaming 3x3 convolution over a raster-order frame with valid/ready handshakes
//   CLK, RST               clock, async active-high reset
//   IN_VALID/IN_READY      pixel input handshake, IN_PIXEL carries the raster-order pixel
//   OUT_VALID/OUT_READY    result output handshake, OUT_DATA result, OUT_LAST final result of frame
//   COEF_WE/ADDR/DATA      runtime coefficient register write port
module conv2d_stream #(
  parameter int DATA_W = 4,
  parameter int COEF_W = 2,
  parameter int IMG_W = 6,
  parameter int IMG_H = 6,
  parameter int K0 = 1,
  parameter int K1 = 2,
  parameter int K2 = 3,
  parameter int K3 = 1,
  parameter int K4 = 2,
  parameter int K5 = 3,
  parameter int K6 = 1,
  parameter int K7 = 2,
  parameter int K8 = 3,
  localparam int OUT_W = DATA_W + COEF_W + 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [DATA_W-1:0] IN_PIXEL,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [OUT_W-1:0]  OUT_DATA,
  output logic              OUT_LAST,
  input  logic              COEF_WE,
  input  logic [3:0]        COEF_ADDR,
  input  logic [COEF_W-1:0] COEF_DATA
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int PW = DATA_W + COEF_W;
  localparam int KD [9] = '{K0, K1, K2, K3, K4, K5, K6, K7, K8};
  typedef enum logic {FILL, RUN} state_t;
  state_t state, state_nx;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [DATA_W-1:0] lb0 [IMG_W];
  logic [DATA_W-1:0] lb1 [IMG_W];
  logic [DATA_W-1:0] win [3][3];
  logic [COEF_W-1:0] kreg [9];
  logic [PW-1:0] prod [9];
  logic [OUT_W-1:0] sum;
  logic win_v, win_l, prod_v, prod_l;
  logic stall, acc, col_end, row_end;
  // A held result freezes the whole block; nothing moves until it is taken.
  assign stall = OUT_VALID & ~OUT_READY;
  assign IN_READY = ~RST & ~stall;
  assign acc = IN_VALID & IN_READY;
  assign col_end = col == CW'(IMG_W - 1);
  assign row_end = row == RW'(IMG_H - 1);
  always_comb begin
    state_nx = !(acc && col_end) ? state :
               (state == FILL && row == RW'(1)) ? RUN :
               (state == RUN && row_end) ? FILL : state;
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= FILL;
      col <= '0;
      row <= '0;
      win_v <= 1'b0;
      win_l <= 1'b0;
      prod_v <= 1'b0;
      prod_l <= 1'b0;
      OUT_VALID <= 1'b0;
      OUT_LAST <= 1'b0;
      OUT_DATA <= '0;
      for (int n = 0; n < 9; n++) kreg[n] <= COEF_W'(KD[n]);
    end else begin
      if (COEF_WE && COEF_ADDR <= 4'd8) kreg[COEF_ADDR] <= COEF_DATA;
      state <= state_nx;
      if (acc) begin
        col <= col_end ? '0 : col + CW'(1);
        row <= !col_end ? row : row_end ? '0 : row + RW'(1);
      end
      if (!stall) begin
        win_v <= acc && state == RUN && col >= CW'(2);
        win_l <= acc && row_end && col_end;
        prod_v <= win_v;
        prod_l <= win_l;
        OUT_VALID <= prod_v;
        OUT_LAST <= prod_l;
        OUT_DATA <= sum;
      end
    end
  end
  // Line buffers hold rows r-1 (lb0) and r-2 (lb1); stale contents are masked by win_v.
  always_ff @(posedge CLK) begin
    if (acc) begin
      lb0[col] <= IN_PIXEL;
      lb1[col] <= lb0[col];
      for (int i = 0; i < 3; i++) begin
        win[i][0] <= win[i][1];
        win[i][1] <= win[i][2];
      end
      win[0][2] <= lb1[col];
      win[1][2] <= lb0[col];
      win[2][2] <= IN_PIXEL;
    end
  end
  // Kernel is applied flipped: top-left pixel meets the last coefficient.
  always_ff @(posedge CLK) begin
    if (!stall)
      for (int n = 0; n < 9; n++) prod[n] <= PW'(win[n / 3][n % 3]) * PW'(kreg[8 - n]);
  end
  always_comb begin
    sum = '0;
    for (int n = 0; n < 9; n++) sum = sum + OUT_W'(prod[n]);
  end
endmodule

// File: tb/tb_conv2d_stream.sv
// tb_conv2d_stream: directed self-checking bench for conv2d_stream
module tb_conv2d_stream;
  localparam int DATA_W = 4;
  localparam int COEF_W = 2;
  localparam int OUT_W = DATA_W + COEF_W + 4;
  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic IN_VALID = 1'b0;
  logic IN_READY;
  logic [DATA_W-1:0] IN_PIXEL = '0;
  logic OUT_VALID;
  logic OUT_READY = 1'b1;
  logic [OUT_W-1:0] OUT_DATA;
  logic OUT_LAST;
  logic COEF_WE = 1'b0;
  logic [3:0] COEF_ADDR = '0;
  logic [COEF_W-1:0] COEF_DATA = '0;
  int n_vec = 0;
  int n_err = 0;
  logic [OUT_W-1:0] rq_d [$];
  logic rq_l [$];
  logic [DATA_W-1:0] img [36];
  int km [9];
  logic [OUT_W-1:0] exp_d [16];

  always #5 CLK = ~CLK;

  conv2d_stream dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_PIXEL(IN_PIXEL),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA), .OUT_LAST(OUT_LAST),
    .COEF_WE(COEF_WE), .COEF_ADDR(COEF_ADDR), .COEF_DATA(COEF_DATA)
  );

  always @(negedge CLK)
    if (!RST && OUT_VALID && OUT_READY) begin
      rq_d.push_back(OUT_DATA);
      rq_l.push_back(OUT_LAST);
    end

  function automatic void build_exp();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        int s;
        s = 0;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            s += int'(img[(r + i) * 6 + c + j]) * km[8 - (3 * i + j)];
        exp_d[r * 4 + c] = OUT_W'(s);
      end
  endfunction

  function automatic void set_ramp();
    for (int i = 0; i < 36; i++) img[i] = DATA_W'((i + 1) % 16);
    km = '{1, 2, 3, 1, 2, 3, 1, 2, 3};
    build_exp();
  endfunction

  task automatic push(input logic [DATA_W-1:0] p, input int gap);
    int t;
    repeat (gap) begin @(posedge CLK); #1; end
    IN_VALID = 1'b1;
    IN_PIXEL = p;
    t = 0;
    do begin @(negedge CLK); t++; end while (!IN_READY && t < 50);
    if (!IN_READY) begin
      n_vec++; n_err++;
      $display("FAIL push_timeout in_ready stuck low after %0d cycles", t);
    end
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
  endtask

  task automatic send(input int from, input int to, input int maxgap);
    for (int i = from; i < to; i++) push(img[i], maxgap > 0 ? int'($urandom_range(maxgap, 0)) : 0);
  endtask

  task automatic wait_res(input int n);
    int t;
    t = 0;
    while (rq_d.size() < n && t < 400) begin @(negedge CLK); t++; end
    repeat (6) @(negedge CLK);
    @(posedge CLK); #1;
  endtask

  task automatic wr_coef(input logic [3:0] a, input logic [COEF_W-1:0] d);
    COEF_WE = 1'b1; COEF_ADDR = a; COEF_DATA = d;
    @(posedge CLK); #1;
    COEF_WE = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge CLK); #2 RST = 1'b1;
    @(posedge CLK); #1 RST = 1'b0;
    rq_d.delete(); rq_l.delete();
  endtask

  task automatic test_reset();
    #3 RST = 1'b1;
    #1;
    n_vec++; if (OUT_VALID !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got %b want 0", OUT_VALID); end
    n_vec++; if (OUT_LAST !== 1'b0) begin n_err++; $display("FAIL rst_out_last got %b want 0", OUT_LAST); end
    n_vec++; if (OUT_DATA !== '0) begin n_err++; $display("FAIL rst_out_data got %0d want 0", OUT_DATA); end
    n_vec++; if (IN_READY !== 1'b0) begin n_err++; $display("FAIL rst_in_ready got %b want 0", IN_READY); end
    @(posedge CLK); @(posedge CLK); #1 RST = 1'b0;
    @(negedge CLK);
    n_vec++; if (IN_READY !== 1'b1) begin n_err++; $display("FAIL post_rst_in_ready got %b want 1", IN_READY); end
    n_vec++; if (OUT_VALID !== 1'b0) begin n_err++; $display("FAIL post_rst_out_valid got %b want 0", OUT_VALID); end
    @(posedge CLK); #1;
  endtask

  task automatic test_frame();
    set_ramp();
    rq_d.delete(); rq_l.delete();
    send(0, 15, 0);
    @(negedge CLK);
    n_vec++; if (OUT_VALID !== 1'b0) begin n_err++; $display("FAIL lat_cyc1 out_valid got %b want 0", OUT_VALID); end
    @(negedge CLK);
    n_vec++; if (OUT_VALID !== 1'b0) begin n_err++; $display("FAIL lat_cyc2 out_valid got %b want 0", OUT_VALID); end
    @(negedge CLK);
    n_vec++; if (OUT_VALID !== 1'b1) begin n_err++; $display("FAIL lat_cyc3 out_valid got %b want 1", OUT_VALID); end
    n_vec++; if (OUT_DATA !== OUT_W'(138)) begin n_err++; $display("FAIL lat_first_data got %0d want 138", OUT_DATA); end
    @(posedge CLK); #1;
    send(15, 36, 0);
    wait_res(16);
    n_vec++; if (rq_d.size() != 16) begin n_err++; $display("FAIL frame_count got %0d want 16", rq_d.size()); end
    for (int i = 0; i < 16 && i < rq_d.size(); i++) begin
      n_vec++; if (rq_d[i] !== exp_d[i]) begin n_err++; $display("FAIL frame_data[%0d] got %0d want %0d", i, rq_d[i], exp_d[i]); end
      n_vec++; if (rq_l[i] !== (i == 15)) begin n_err++; $display("FAIL frame_last[%0d] got %b want %b", i, rq_l[i], i == 15); end
    end
  endtask

  task automatic test_coef();
    set_ramp();
    wr_coef(4'd4, 2'd0);
    wr_coef(4'd9, 2'd0);
    wr_coef(4'd15, 2'd0);
    km[4] = 0;
    build_exp();
    rq_d.delete(); rq_l.delete();
    send(0, 36, 0);
    wait_res(16);
    n_vec++; if (rq_d.size() != 16) begin n_err++; $display("FAIL coef_count got %0d want 16", rq_d.size()); end
    n_vec++; if (rq_d.size() > 0 && rq_d[0] !== OUT_W'(122)) begin n_err++; $display("FAIL coef_first got %0d want 122", rq_d[0]); end
    for (int i = 0; i < 16 && i < rq_d.size(); i++) begin
      n_vec++; if (rq_d[i] !== exp_d[i]) begin n_err++; $display("FAIL coef_data[%0d] got %0d want %0d", i, rq_d[i], exp_d[i]); end
    end
    do_reset();
  endtask

  task automatic test_full_scale();
    for (int n = 0; n < 9; n++) wr_coef(4'(n), 2'd3);
    for (int i = 0; i < 36; i++) img[i] = 4'd15;
    send(0, 36, 1);
    wait_res(16);
    n_vec++; if (rq_d.size() != 16) begin n_err++; $display("FAIL full_count got %0d want 16", rq_d.size()); end
    for (int i = 0; i < 16 && i < rq_d.size(); i++) begin
      n_vec++; if (rq_d[i] !== OUT_W'(405)) begin n_err++; $display("FAIL full_data[%0d] got %0d want 405", i, rq_d[i]); end
    end
    do_reset();
  endtask

  task automatic test_stall();
    set_ramp();
    rq_d.delete(); rq_l.delete();
    fork
      send(0, 36, 0);
      begin : stall_drv
        int t;
        logic [OUT_W-1:0] held;
        t = 0;
        while (rq_d.size() < 3 && t < 200) begin @(negedge CLK); t++; end
        @(posedge CLK); #1;
        t = 0;
        while (!OUT_VALID && t < 50) begin @(posedge CLK); #1; t++; end
        OUT_READY = 1'b0;
        held = OUT_DATA;
        n_vec++; if (held !== exp_d[rq_d.size()]) begin n_err++; $display("FAIL stall_held got %0d want %0d", held, exp_d[rq_d.size()]); end
        repeat (5) begin
          @(negedge CLK);
          n_vec++; if (OUT_VALID !== 1'b1) begin n_err++; $display("FAIL stall_valid got %b want 1", OUT_VALID); end
          n_vec++; if (OUT_DATA !== held) begin n_err++; $display("FAIL stall_data got %0d want %0d", OUT_DATA, held); end
          n_vec++; if (IN_READY !== 1'b0) begin n_err++; $display("FAIL stall_in_ready got %b want 0", IN_READY); end
        end
        @(posedge CLK); #1;
        OUT_READY = 1'b1;
      end
    join
    wait_res(16);
    n_vec++; if (rq_d.size() != 16) begin n_err++; $display("FAIL stall_count got %0d want 16", rq_d.size()); end
    for (int i = 0; i < 16 && i < rq_d.size(); i++) begin
      n_vec++; if (rq_d[i] !== exp_d[i]) begin n_err++; $display("FAIL stall_order[%0d] got %0d want %0d", i, rq_d[i], exp_d[i]); end
      n_vec++; if (rq_l[i] !== (i == 15)) begin n_err++; $display("FAIL stall_last[%0d] got %b want %b", i, rq_l[i], i == 15); end
    end
  endtask

  task automatic test_reset_mid();
    set_ramp();
    send(0, 20, 0);
    repeat (4) @(posedge CLK);
    #2 RST = 1'b1;
    #1;
    n_vec++; if (OUT_VALID !== 1'b0) begin n_err++; $display("FAIL mid_rst_valid got %b want 0", OUT_VALID); end
    n_vec++; if (IN_READY !== 1'b0) begin n_err++; $display("FAIL mid_rst_in_ready got %b want 0", IN_READY); end
    @(posedge CLK); #1 RST = 1'b0;
    rq_d.delete(); rq_l.delete();
    send(0, 14, 0);
    repeat (4) @(negedge CLK);
    n_vec++; if (rq_d.size() != 0) begin n_err++; $display("FAIL mid_early_out got %0d results want 0", rq_d.size()); end
    @(posedge CLK); #1;
    send(14, 36, 0);
    wait_res(16);
    n_vec++; if (rq_d.size() != 16) begin n_err++; $display("FAIL mid_count got %0d want 16", rq_d.size()); end
    n_vec++; if (rq_d.size() > 0 && rq_d[0] !== OUT_W'(138)) begin n_err++; $display("FAIL mid_first got %0d want 138", rq_d[0]); end
    for (int i = 0; i < 16 && i < rq_d.size(); i++) begin
      n_vec++; if (rq_d[i] !== exp_d[i]) begin n_err++; $display("FAIL mid_data[%0d] got %0d want %0d", i, rq_d[i], exp_d[i]); end
    end
  endtask

  task automatic test_back_to_back();
    set_ramp();
    rq_d.delete(); rq_l.delete();
    send(0, 36, 2);
    send(0, 36, 2);
    wait_res(32);
    n_vec++; if (rq_d.size() != 32) begin n_err++; $display("FAIL b2b_count got %0d want 32", rq_d.size()); end
    for (int i = 0; i < 32 && i < rq_d.size(); i++) begin
      n_vec++; if (rq_d[i] !== exp_d[i % 16]) begin n_err++; $display("FAIL b2b_data[%0d] got %0d want %0d", i, rq_d[i], exp_d[i % 16]); end
      n_vec++; if (rq_l[i] !== (i % 16 == 15)) begin n_err++; $display("FAIL b2b_last[%0d] got %b want %b", i, rq_l[i], i % 16 == 15); end
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_coef();
    test_full_scale();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end
endmodule
